io_responder: RTL
=================

IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 Parameter DBITS, default 16: data/address bus width.
REQ-002 Parameter DEB_CYCLES, default 500000: stable-input cycles required before a key level is accepted.
REQ-003 Parameter TICK_DIV, default 50000: clock cycles per timer tick.
REQ-004 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-005 RST_N  input  1  asynchronous reset, active-low.
REQ-006 ADDR  input  DBITS  processor data address.
REQ-007 WDATA  input  DBITS  processor store data.
REQ-008 WE  input  1  processor store strobe, one cycle per store.
REQ-009 SEL  output  1  high when ADDR[15:4]==12'hFFF; combinational.
REQ-010 RDATA  output  DBITS  load data for ADDR; combinational.
REQ-011 KEY_IN  input  4  raw pushbuttons, asynchronous, 0 = pressed.
REQ-012 SW_IN  input  10  raw switches, asynchronous.
REQ-013 HEX_OUT  output  16  four hex digits to seven-segment decoders.
REQ-014 LEDR_OUT  output  10  red LEDs.
REQ-015 LEDG_OUT  output  8  green LEDs.

Function
REQ-016 Register map, byte addresses: FFF0 KEYS (RO), FFF2 SWITCHES (RO), FFF4 KEYEDGE (R/W1C), FFF6 TCNT (R/W), FFF8 HEX (R/W), FFFA LEDR (R/W), FFFC LEDG (R/W), FFFE TCTL (R/W).
REQ-017 Writes take effect only when WE && SEL, at the posedge ending the write cycle; read value changes the following cycle.
REQ-018 RDATA zero-extends narrow registers; unmapped offsets within SEL range and any ADDR with SEL low SHALL return 16'hDEAD.
REQ-019 Writes to KEYS, SWITCHES, or unmapped addresses SHALL be ignored.
REQ-020 KEY_IN and SW_IN each pass through a two-flop synchronizer; SWITCHES reads the second flop (2-cycle latency, no debounce).
REQ-021 Per key: counter resets whenever synced level equals accepted level; otherwise increments; on reaching DEB_CYCLES-1 accepted level takes synced level and counter resets.
REQ-022 KEYS reads {12'b0, accepted levels} (active-low, as raw).
REQ-023 Accepted level 1->0 transition SHALL set the corresponding KEYEDGE bit; 0->1 SHALL not.
REQ-024 KEYEDGE write clears bits where WDATA[3:0]=1; a set and a clear on the same bit in the same cycle: set wins.
REQ-025 HEX stores WDATA[15:0]; LEDR stores WDATA[9:0]; LEDG stores WDATA[7:0]; outputs drive stored values directly.
REQ-026 TCTL bit0 = EN (R/W), bit1 = WRAP (sticky; write 1 clears); other bits read 0.
REQ-027 EN=1: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 prescaler returns to 0 and TCNT increments by 1.
REQ-028 TCNT FFFF+1 wraps to 0000 and sets WRAP; simultaneous wrap and W1C of WRAP: set wins.
REQ-029 EN=0: prescaler and TCNT hold.
REQ-030 TCNT write loads WDATA and resets prescaler to 0; a write coinciding with a tick: write wins, no increment, no WRAP.
REQ-031 Writing TCTL with EN changing 0->1 resets prescaler to 0.

Reset
REQ-032 RST_N low SHALL asynchronously force: HEX_OUT 0, LEDR_OUT 0, LEDG_OUT 0, KEYEDGE 0, TCNT 0, TCTL 0, prescaler 0, debounce counters 0, synchronizers and accepted key levels 4'hF, switch synchronizers 0.
REQ-033 Reset mid-debounce or mid-tick SHALL discard partial counts; no KEYEDGE bit sets on reset release.

Verification
REQ-034 Write 16'h1234 to FFF8, 16'hFFFF to FFFA, 16'h00A5 to FFFC -> HEX_OUT=1234, LEDR_OUT=3FF, LEDG_OUT=A5; reads return 1234, 03FF, 00A5; read FFF1-aligned unmapped/0x0100 -> DEAD.
REQ-035 DEB_CYCLES=4: KEY_IN[1] low for 3 cycles then high -> KEYS stays 000F; low for 8 cycles -> KEYS=000D and KEYEDGE=0002.
REQ-036 KEYEDGE=0002, write 0002 to FFF4 in the same cycle a new KEY[1] acceptance occurs -> KEYEDGE remains 0002; next write of 0002 alone -> 0000.
REQ-037 TICK_DIV=3, TCNT loaded FFFE, TCTL=1 -> TCNT=FFFF after 3 cycles, 0000 after 6, TCTL reads 0003; write 0002 to FFFE -> reads 0001.
REQ-038 Assert RST_N low asynchronously mid-operation with all registers non-zero -> all outputs 0, KEYS=000F immediately, no KEYEDGE bits after release.
REQ-039 SW_IN=3FF -> SWITCHES read 0000 for 2 cycles, then 03FF.

Source files
------------

// File: rtl/io_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : io_responder_if
// Brief   : Processor load/store bus between a CPU core and io_responder.
// Rev     : 1.0  initial release
// ============================================================================
interface io_responder_if #(
  parameter int DBITS = 16
) ();
  logic [DBITS-1:0] addr;
  logic [DBITS-1:0] wdata;
  logic             we;
  logic             sel;
  logic [DBITS-1:0] rdata;

  modport master (
    output addr, wdata, we,
    input  sel, rdata
  );

  modport slave (
    input  addr, wdata, we,
    output sel, rdata
  );
endinterface
`default_nettype wire

// File: rtl/io_responder.sv
`default_nettype none
// ============================================================================
// Module  : io_responder
// Brief   : Memory-mapped keys, switches, hex/LED outputs and tick timer.
// Rev     : 1.0  initial release
// ============================================================================
module io_responder #(
  parameter int DBITS      = 16,
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 50000
) (
  input  logic          clk,
  input  logic          rst_n,
  io_responder_if.slave bus,
  input  logic [3:0]    key_i,
  input  logic [9:0]    sw_i,
  output logic [15:0]   hex_o,
  output logic [9:0]    ledr_o,
  output logic [7:0]    ledg_o
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [DBITS-1:0] RD_DEAD = DBITS'(16'hDEAD);

  localparam logic [3:0] OFF_KEYS    = 4'h0;
  localparam logic [3:0] OFF_SW      = 4'h2;
  localparam logic [3:0] OFF_KEYEDGE = 4'h4;
  localparam logic [3:0] OFF_TCNT    = 4'h6;
  localparam logic [3:0] OFF_HEX     = 4'h8;
  localparam logic [3:0] OFF_LEDR    = 4'hA;
  localparam logic [3:0] OFF_LEDG    = 4'hC;
  localparam logic [3:0] OFF_TCTL    = 4'hE;

  logic [3:0]       key_s1_q, key_s2_q, key_acc_q, key_acc_d;
  logic [9:0]       sw_s1_q, sw_s2_q;
  logic [DEB_W-1:0] deb_cnt_q [4];
  logic [DEB_W-1:0] deb_cnt_d [4];
  logic [3:0]       keyedge_q, keyedge_d;
  logic [15:0]      hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic             en_q, en_d;
  logic             wrap_q, wrap_d;

  logic             w_sel;
  logic [3:0]       w_off;
  logic             w_wr;
  logic [DBITS-1:0] w_rdata;
  logic             w_tick;
  logic             w_wrap_set;

  assign w_sel     = (bus.addr[15:4] == 12'hFFF);
  assign w_off     = bus.addr[3:0];
  assign w_wr      = bus.we && w_sel;
  assign bus.sel   = w_sel;
  assign bus.rdata = w_rdata;

  assign hex_o  = hex_q;
  assign ledr_o = ledr_q;
  assign ledg_o = ledg_q;

  always_comb begin
    w_rdata = RD_DEAD;
    if (w_sel) begin
      case (w_off)
        OFF_KEYS:    w_rdata = DBITS'({12'h000, key_acc_q});
        OFF_SW:      w_rdata = DBITS'({6'h00, sw_s2_q});
        OFF_KEYEDGE: w_rdata = DBITS'({12'h000, keyedge_q});
        OFF_TCNT:    w_rdata = DBITS'(tcnt_q);
        OFF_HEX:     w_rdata = DBITS'(hex_q);
        OFF_LEDR:    w_rdata = DBITS'({6'h00, ledr_q});
        OFF_LEDG:    w_rdata = DBITS'({8'h00, ledg_q});
        OFF_TCTL:    w_rdata = DBITS'({14'h0000, wrap_q, en_q});
        default:     w_rdata = RD_DEAD;
      endcase
    end
  end

  // Debounce: a key level is accepted only after DEB_CYCLES of disagreement.
  always_comb begin
    key_acc_d = key_acc_q;
    deb_cnt_d = deb_cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (key_s2_q[k] == key_acc_q[k]) begin
        deb_cnt_d[k] = '0;
      end else if (deb_cnt_q[k] == DEB_MAX) begin
        key_acc_d[k] = key_s2_q[k];
        deb_cnt_d[k] = '0;
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k] + 1'b1;
      end
    end
  end

  // Falling accepted level sets the edge flag, and a set beats a same-cycle clear.
  always_comb begin
    keyedge_d = keyedge_q | (key_acc_q & ~key_acc_d);
    if (w_wr && (w_off == OFF_KEYEDGE)) begin
      keyedge_d = (keyedge_q & ~bus.wdata[3:0]) | (key_acc_q & ~key_acc_d);
    end
  end

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (w_wr && (w_off == OFF_HEX))  hex_d  = bus.wdata[15:0];
    if (w_wr && (w_off == OFF_LEDR)) ledr_d = bus.wdata[9:0];
    if (w_wr && (w_off == OFF_LEDG)) ledg_d = bus.wdata[7:0];
  end

  assign w_tick = en_q && (presc_q == PRE_MAX);

  // A processor load of TCNT overrides a coincident tick entirely.
  always_comb begin
    tcnt_d     = tcnt_q;
    presc_d    = presc_q;
    w_wrap_set = 1'b0;
    if (w_wr && (w_off == OFF_TCNT)) begin
      tcnt_d  = bus.wdata[15:0];
      presc_d = '0;
    end else if (w_tick) begin
      tcnt_d     = tcnt_q + 16'd1;
      presc_d    = '0;
      w_wrap_set = (tcnt_q == 16'hFFFF);
    end else if (en_q) begin
      presc_d = presc_q + 1'b1;
    end
    if (w_wr && (w_off == OFF_TCTL) && !en_q && bus.wdata[0]) begin
      presc_d = '0;
    end
  end

  always_comb begin
    en_d   = en_q;
    wrap_d = wrap_q;
    if (w_wr && (w_off == OFF_TCTL)) begin
      en_d   = bus.wdata[0];
      wrap_d = wrap_q & ~bus.wdata[1];
    end
    if (w_wrap_set) wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= 4'hF;
      key_s2_q  <= 4'hF;
      key_acc_q <= 4'hF;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      for (int k = 0; k < 4; k++) deb_cnt_q[k] <= '0;
      keyedge_q <= '0;
      hex_q     <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      tcnt_q    <= '0;
      presc_q   <= '0;
      en_q      <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      key_s1_q  <= key_i;
      key_s2_q  <= key_s1_q;
      key_acc_q <= key_acc_d;
      sw_s1_q   <= sw_i;
      sw_s2_q   <= sw_s1_q;
      for (int k = 0; k < 4; k++) deb_cnt_q[k] <= deb_cnt_d[k];
      keyedge_q <= keyedge_d;
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      tcnt_q    <= tcnt_d;
      presc_q   <= presc_d;
      en_q      <= en_d;
      wrap_q    <= wrap_d;
    end
  end

endmodule
`default_nettype wire
